av_config_sequencer: RTL and testbench

//  Boot-time/on-demand configurator for the audio codec on the av_config 2-wire bus (SDAT/SCLK).

---
 rtl/av_config_sequencer.sv | 163 ++++++++++++++++
 tb/tb_av_config_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/av_config_sequencer.sv
// Walks an external table of 16-bit codec register words and sends each one as a
// 3-byte write on the av_config 2-wire bus, retrying NACKed entries.
module av_config_sequencer #(
   parameter int         CLK_HZ     = 50_000_000,
   parameter int         I2C_HZ     = 100_000,
   parameter logic [6:0] DEV_ADDR   = 7'h1A,
   parameter int         NUM_REGS   = 11,
   parameter int         MAX_RETRY  = 3,
   parameter bit         AUTO_START = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [3:0]  tbl_addr,
   input  logic [15:0] tbl_data,
   output logic        scl_o,
   output logic        sda_oe,
   input  logic        sda_i,
   output logic        busy,
   output logic        done,
   output logic        ack_err
);

   localparam int              DIV       = CLK_HZ / (4 * I2C_HZ);
   localparam int              QW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [QW-1:0]   DIV_M1    = QW'(DIV - 1);
   localparam logic [3:0]      LAST_ADDR = 4'(NUM_REGS - 1);
   localparam int              RW        = $clog2(MAX_RETRY + 2);
   localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [2:0] {IDLE, LOAD, START, BITS, STOP, GAP, DONE} state_t;

   state_t          state, state_n;
   logic [QW-1:0]   qcnt;
   logic [1:0]      q;
   logic [23:0]     shreg;
   logic [3:0]      bit_idx;
   logic [1:0]      byte_idx;
   logic            nack;
   logic            failed;
   logic [RW-1:0]   rcnt;
   logic            qtick, phase_end, ack_slot, start_ok, abort;

   assign qtick     = (qcnt == DIV_M1);
   assign phase_end = qtick && (q == 2'd3);
   assign ack_slot  = (bit_idx == 4'd8);
   assign start_ok  = (state == IDLE) && start;
   assign abort     = (state == STOP) && phase_end && failed && (rcnt == RETRY_MAX);

   always_ff @(posedge clk) begin
      if (reset) state <= AUTO_START ? LOAD : IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = LOAD;
         LOAD:    state_n = START;
         START:   if (phase_end) state_n = BITS;
         BITS:    if (phase_end && ack_slot && (nack || byte_idx == 2'd2)) state_n = STOP;
         STOP:    if (phase_end) state_n = abort ? IDLE : GAP;
         GAP:     if (phase_end) state_n = (!failed && tbl_addr == LAST_ADDR) ? DONE : LOAD;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Bus levels are a pure decode of registered state, so they only move on quarter boundaries.
   always_comb begin
      scl_o  = 1'b1;
      sda_oe = 1'b0;
      case (state)
         START: begin
            scl_o  = (q != 2'd3);
            sda_oe = (q != 2'd0);
         end
         BITS: begin
            scl_o  = (q == 2'd1) || (q == 2'd2);
            sda_oe = !ack_slot && !shreg[23];
         end
         STOP: begin
            scl_o  = (q != 2'd0);
            sda_oe = (q == 2'd0) || (q == 2'd1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || state == IDLE || state == LOAD || state == DONE) begin
         qcnt <= '0;
         q    <= 2'd0;
      end else if (qtick) begin
         qcnt <= '0;
         q    <= q + 2'd1;
      end else begin
         qcnt <= qcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_idx  <= 4'd0;
         byte_idx <= 2'd0;
      end else if (state == LOAD) begin
         bit_idx  <= 4'd0;
         byte_idx <= 2'd0;
      end else if (state == BITS && phase_end) begin
         if (ack_slot) begin
            bit_idx  <= 4'd0;
            byte_idx <= byte_idx + 2'd1;
         end else begin
            bit_idx  <= bit_idx + 4'd1;
         end
      end
   end

   // Shift register and ACK sample carry no reset: they are always reloaded/resampled before use.
   always_ff @(posedge clk) begin
      if (state == LOAD)
         shreg <= {DEV_ADDR, 1'b0, tbl_data};
      else if (state == BITS && phase_end && !ack_slot)
         shreg <= {shreg[22:0], 1'b0};
      if (state == BITS && q == 2'd1 && qtick && ack_slot)
         nack <= sda_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tbl_addr <= 4'd0;
         rcnt     <= '0;
         failed   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ack_err  <= 1'b0;
      end else begin
         busy <= (state_n != IDLE);
         if (start_ok) begin
            tbl_addr <= 4'd0;
            rcnt     <= '0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
         end
         if (state == LOAD)
            failed <= 1'b0;
         if (state == BITS && phase_end && ack_slot)
            failed <= nack;
         if (state == STOP && phase_end && failed && !abort)
            rcnt <= rcnt + 1'b1;
         if (abort)
            ack_err <= 1'b1;
         // A failed write falls through GAP back to LOAD with the same index.
         if (state == GAP && phase_end && !failed && tbl_addr != LAST_ADDR) begin
            tbl_addr <= tbl_addr + 4'd1;
            rcnt     <= '0;
         end
         if (state == DONE)
            done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_av_config_sequencer.sv
// Directed bench for av_config_sequencer: a bus decoder/slave model on the 2-wire lines
// plus per-scenario tasks with hand-computed byte streams and cycle counts.
module tb_av_config_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b1;
   logic [3:0]  tbl_addr;
   logic [15:0] tbl_data;
   logic        scl_o, sda_oe, sda_i, busy, done, ack_err;

   logic        rst_a = 1'b1;
   logic [3:0]  tbl_addr_a;
   logic        scl_o_a, sda_oe_a, busy_a, done_a, ack_err_a;

   int n_checks = 0;
   int n_fails  = 0;

   logic       prev_scl = 1'b1, prev_sda = 1'b1, slave_low = 1'b0;
   logic       dec_s, dec_d;
   logic [7:0] sh = 8'h00;
   int         bitc = 0, byte_ix = 0, n_starts = 0, n_stops = 0;
   int         nack_start = -1;
   bit         nack_addr = 1'b0;
   logic [7:0] rx_q[$];

   always #5 clk = ~clk;

   assign tbl_data = (tbl_addr == 4'd0) ? 16'h001E : 16'hA53C;
   assign sda_i    = !(sda_oe || slave_low);

   av_config_sequencer #(
      .CLK_HZ(400), .I2C_HZ(100), .DEV_ADDR(7'h1A),
      .NUM_REGS(2), .MAX_RETRY(3), .AUTO_START(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i),
      .busy(busy), .done(done), .ack_err(ack_err)
   );

   av_config_sequencer #(
      .CLK_HZ(400), .I2C_HZ(100), .DEV_ADDR(7'h1A),
      .NUM_REGS(2), .MAX_RETRY(3), .AUTO_START(1'b1)
   ) dut_auto (
      .clk(clk), .reset(rst_a), .start(1'b0), .tbl_addr(tbl_addr_a), .tbl_data(16'h001E),
      .scl_o(scl_o_a), .sda_oe(sda_oe_a), .sda_i(!sda_oe_a),
      .busy(busy_a), .done(done_a), .ack_err(ack_err_a)
   );

   // Bus decoder and slave: START/STOP, byte capture on SCL rise, ACK driven after the 8th bit.
   initial begin
      forever begin
         @(negedge clk);
         dec_s = scl_o;
         dec_d = sda_i;
         if (prev_scl && dec_s && prev_sda && !dec_d) begin
            n_starts++;
            bitc    = 0;
            byte_ix = 0;
         end else if (prev_scl && dec_s && !prev_sda && dec_d) begin
            n_stops++;
            bitc = 0;
         end else if (!prev_scl && dec_s) begin
            if (bitc < 8) begin
               sh = {sh[6:0], dec_d};
               bitc++;
            end else begin
               rx_q.push_back(sh);
               byte_ix++;
               bitc = 0;
            end
         end else if (prev_scl && !dec_s) begin
            if (bitc == 8)
               slave_low = !((nack_addr && byte_ix == 0) || (byte_ix == 2 && n_starts == nack_start));
            else
               slave_low = 1'b0;
         end
         prev_scl = dec_s;
         prev_sda = dec_d;
      end
   end

   // Pulses start, then counts edges until done or ack_err rises; p1/p2 add extra start pulses.
   task automatic run_table(input int p1, input int p2, output logic b1, output int endc);
      int cyc;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      b1 = busy;
      start = 1'b0;
      cyc  = 0;
      endc = -1;
      while (cyc < 3000 && endc < 0) begin
         @(posedge clk); #1;
         cyc++;
         if (done || ack_err) endc = cyc;
         start = (cyc == p1) || (cyc == p2);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      int s0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (scl_o !== 1'b1) begin n_fails++; $display("FAIL rst_scl: got %0b expected 1", scl_o); end
      n_checks++; if (sda_oe !== 1'b0) begin n_fails++; $display("FAIL rst_sda_oe: got %0b expected 0", sda_oe); end
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_busy: got %0b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL rst_done: got %0b expected 0", done); end
      n_checks++; if (ack_err !== 1'b0) begin n_fails++; $display("FAIL rst_ack_err: got %0b expected 0", ack_err); end
      n_checks++; if (tbl_addr !== 4'd0) begin n_fails++; $display("FAIL rst_tbl_addr: got %0d expected 0", tbl_addr); end
      s0 = n_starts;
      reset = 1'b0;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_start_ignored_busy: got %0b expected 0", busy); end
      n_checks++; if (n_starts !== s0) begin n_fails++; $display("FAIL rst_start_ignored_bus: got %0d starts expected %0d", n_starts, s0); end
   endtask

   task automatic test_auto_start();
      int   hit;
      logic prev_oe;
      hit = -1;
      @(posedge clk); #1;
      n_checks++; if (scl_o_a !== 1'b1 || sda_oe_a !== 1'b0) begin n_fails++; $display("FAIL auto_rst_bus: got scl=%0b oe=%0b expected 1 0", scl_o_a, sda_oe_a); end
      n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || ack_err_a !== 1'b0 || tbl_addr_a !== 4'd0) begin
         n_fails++; $display("FAIL auto_rst_status: got busy=%0b done=%0b err=%0b addr=%0d expected 0 0 0 0", busy_a, done_a, ack_err_a, tbl_addr_a);
      end
      rst_a   = 1'b0;
      prev_oe = sda_oe_a;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         if (hit < 0 && sda_oe_a && !prev_oe && scl_o_a) hit = k;
         prev_oe = sda_oe_a;
      end
      n_checks++; if (hit !== 2) begin n_fails++; $display("FAIL auto_first_start: got clk %0d expected 2", hit); end
      n_checks++; if (busy_a !== 1'b1) begin n_fails++; $display("FAIL auto_busy: got %0b expected 1", busy_a); end
      rst_a = 1'b1;
   endtask

   task automatic test_single_run();
      logic       b1;
      logic [7:0] got;
      int         endc, b0, s0, p0;
      logic [7:0] exp [6];
      exp = '{8'h34, 8'h00, 8'h1E, 8'h34, 8'hA5, 8'h3C};
      b0 = rx_q.size(); s0 = n_starts; p0 = n_stops;
      run_table(-1, -1, b1, endc);
      n_checks++; if (b1 !== 1'b1) begin n_fails++; $display("FAIL run_busy_next: got %0b expected 1", b1); end
      n_checks++; if (endc !== 243) begin n_fails++; $display("FAIL run_done_clk: got %0d expected 243", endc); end
      n_checks++; if (rx_q.size() - b0 !== 6) begin n_fails++; $display("FAIL run_byte_count: got %0d expected 6", rx_q.size() - b0); end
      for (int i = 0; i < 6; i++) begin
         got = 'x;
         if (b0 + i < rx_q.size()) got = rx_q[b0 + i];
         n_checks++; if (got !== exp[i]) begin n_fails++; $display("FAIL run_byte%0d: got %02h expected %02h", i, got, exp[i]); end
      end
      n_checks++; if (n_starts - s0 !== 2 || n_stops - p0 !== 2) begin
         n_fails++; $display("FAIL run_start_stop: got %0d/%0d expected 2/2", n_starts - s0, n_stops - p0);
      end
      n_checks++; if (done !== 1'b1 || busy !== 1'b0 || ack_err !== 1'b0) begin
         n_fails++; $display("FAIL run_status: got done=%0b busy=%0b err=%0b expected 1 0 0", done, busy, ack_err);
      end
      n_checks++; if (tbl_addr !== 4'd1) begin n_fails++; $display("FAIL run_tbl_addr: got %0d expected 1", tbl_addr); end
   endtask

   task automatic test_nack_addr();
      logic b1;
      int   endc, b0, s0, p0, n34;
      b0 = rx_q.size(); s0 = n_starts; p0 = n_stops;
      nack_addr = 1'b1;
      run_table(-1, -1, b1, endc);
      nack_addr = 1'b0;
      n34 = 0;
      for (int i = b0; i < rx_q.size(); i++) if (rx_q[i] == 8'h34) n34++;
      n_checks++; if (endc !== 192) begin n_fails++; $display("FAIL nack_err_clk: got %0d expected 192", endc); end
      n_checks++; if (rx_q.size() - b0 !== 4 || n34 !== 4) begin
         n_fails++; $display("FAIL nack_bytes: got %0d bytes (%0d addr) expected 4 (4)", rx_q.size() - b0, n34);
      end
      n_checks++; if (n_starts - s0 !== 4 || n_stops - p0 !== 4) begin
         n_fails++; $display("FAIL nack_attempts: got %0d/%0d expected 4/4", n_starts - s0, n_stops - p0);
      end
      n_checks++; if (ack_err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
         n_fails++; $display("FAIL nack_status: got err=%0b done=%0b busy=%0b expected 1 0 0", ack_err, done, busy);
      end
      n_checks++; if (tbl_addr !== 4'd0) begin n_fails++; $display("FAIL nack_tbl_addr: got %0d expected 0", tbl_addr); end
   endtask

   task automatic test_nack_retry_data();
      logic       b1;
      logic [7:0] got;
      int         endc, b0, s0;
      logic [7:0] exp [9];
      exp = '{8'h34, 8'h00, 8'h1E, 8'h34, 8'hA5, 8'h3C, 8'h34, 8'hA5, 8'h3C};
      b0 = rx_q.size(); s0 = n_starts;
      nack_start = s0 + 2;
      run_table(-1, -1, b1, endc);
      nack_start = -1;
      n_checks++; if (endc !== 364) begin n_fails++; $display("FAIL retry_done_clk: got %0d expected 364", endc); end
      n_checks++; if (rx_q.size() - b0 !== 9) begin n_fails++; $display("FAIL retry_byte_count: got %0d expected 9", rx_q.size() - b0); end
      for (int i = 0; i < 9; i++) begin
         got = 'x;
         if (b0 + i < rx_q.size()) got = rx_q[b0 + i];
         n_checks++; if (got !== exp[i]) begin n_fails++; $display("FAIL retry_byte%0d: got %02h expected %02h", i, got, exp[i]); end
      end
      n_checks++; if (n_starts - s0 !== 3) begin n_fails++; $display("FAIL retry_starts: got %0d expected 3", n_starts - s0); end
      n_checks++; if (done !== 1'b1 || ack_err !== 1'b0) begin
         n_fails++; $display("FAIL retry_status: got done=%0b err=%0b expected 1 0", done, ack_err);
      end
   endtask

   task automatic test_reset_mid();
      logic       b1;
      logic [7:0] got;
      int         endc, b0, k;
      logic [7:0] exp [6];
      exp = '{8'h34, 8'h00, 8'h1E, 8'h34, 8'hA5, 8'h3C};
      b0 = rx_q.size();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (rx_q.size() < b0 + 4 && k < 1000) begin
         @(posedge clk); #1;
         k++;
      end
      repeat (10) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b1 || tbl_addr !== 4'd1) begin
         n_fails++; $display("FAIL mid_in_entry1: got busy=%0b addr=%0d expected 1 1", busy, tbl_addr);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (scl_o !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0) begin
         n_fails++; $display("FAIL mid_reset_release: got scl=%0b oe=%0b busy=%0b expected 1 0 0", scl_o, sda_oe, busy);
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      b0 = rx_q.size();
      run_table(-1, -1, b1, endc);
      n_checks++; if (endc !== 243) begin n_fails++; $display("FAIL mid_rerun_clk: got %0d expected 243", endc); end
      for (int i = 0; i < 6; i++) begin
         got = 'x;
         if (b0 + i < rx_q.size()) got = rx_q[b0 + i];
         n_checks++; if (got !== exp[i]) begin n_fails++; $display("FAIL mid_rerun_byte%0d: got %02h expected %02h", i, got, exp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic       b1;
      logic [7:0] got;
      int         endc, b0, s0;
      logic [7:0] exp [6];
      exp = '{8'h34, 8'h00, 8'h1E, 8'h34, 8'hA5, 8'h3C};
      b0 = rx_q.size(); s0 = n_starts;
      run_table(5, 242, b1, endc);
      n_checks++; if (endc !== 243) begin n_fails++; $display("FAIL b2b_done_clk: got %0d expected 243", endc); end
      n_checks++; if (rx_q.size() - b0 !== 6) begin n_fails++; $display("FAIL b2b_byte_count: got %0d expected 6", rx_q.size() - b0); end
      for (int i = 0; i < 6; i++) begin
         got = 'x;
         if (b0 + i < rx_q.size()) got = rx_q[b0 + i];
         n_checks++; if (got !== exp[i]) begin n_fails++; $display("FAIL b2b_byte%0d: got %02h expected %02h", i, got, exp[i]); end
      end
      repeat (8) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0 || n_starts - s0 !== 2) begin
         n_fails++; $display("FAIL b2b_ignored: got busy=%0b starts=%0d expected 0 2", busy, n_starts - s0);
      end
      n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL b2b_done_sticky: got %0b expected 1", done); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_auto_start();
      test_single_run();
      test_nack_addr();
      test_nack_retry_data();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
